// File: rtl/tx_dcoffset_pkg.sv
// tx_dcoffset_pkg: register map, field positions and lane state for the TX DC offset injector
package tx_dcoffset_pkg;
   localparam logic [7:0] REG_I = 8'd0;
   localparam logic [7:0] REG_Q = 8'd1;
   localparam logic [7:0] REG_PERIOD = 8'd2;
   localparam int IMMEDIATE_BIT = 31;
   localparam int PERIOD_LSB = 0;
   localparam int PERIOD_MSB = 15;
   typedef enum logic {IDLE, RAMP} lane_state_t;
endpackage

// File: rtl/dco_ramp_lane.sv
// dco_ramp_lane: one offset lane; holds target, ramps cur toward it in bounded steps
module dco_ramp_lane
   import tx_dcoffset_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEP_SHIFT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic             imm,
   input  logic [WIDTH-1:0] wdata,
   input  logic [15:0]      period,
   output logic [WIDTH-1:0] cur,
   output logic             ramping
);
   localparam logic signed [WIDTH:0] STEP = (WIDTH+1)'(2**STEP_SHIFT);
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(2**STEP_SHIFT);
   logic [WIDTH-1:0] target;
   logic [15:0] timer;
   lane_state_t state;
   logic signed [WIDTH:0] diff;
   logic near;
   logic [WIDTH-1:0] cur_step;
   assign diff = $signed({target[WIDTH-1], target}) - $signed({cur[WIDTH-1], cur});
   assign near = (diff <= STEP) && (diff >= -STEP);
   assign cur_step = diff[WIDTH] ? cur - STEP_W : cur + STEP_W;
   assign ramping = state == RAMP;
   // writes take priority over stepping; ramp steps land exactly on target when close
   always_ff @(posedge clk) begin
      if (rst) begin
         target <= '0;
         cur <= '0;
         timer <= '0;
         state <= IDLE;
      end else if (wr) begin
         target <= wdata;
         if (imm) begin
            cur <= wdata;
            state <= IDLE;
         end else if (state == IDLE && wdata != cur) begin
            state <= RAMP;
            timer <= period;
         end
      end else if (state == RAMP) begin
         if (timer == 16'd0) begin
            cur <= near ? target : cur_step;
            state <= near ? IDLE : RAMP;
            timer <= period;
         end else begin
            timer <= timer - 16'd1;
         end
      end
   end
endmodule

// File: rtl/tx_dcoffset.sv
// tx_dcoffset: adds ramped, programmable I/Q DC offsets to the TX stream with saturation
module tx_dcoffset
   import tx_dcoffset_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter logic [7:0] ADDR = 8'd0,
   parameter int STEP_SHIFT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic [WIDTH-1:0] in_i,
   input  logic [WIDTH-1:0] in_q,
   input  logic             strobe_in,
   output logic [WIDTH-1:0] out_i,
   output logic [WIDTH-1:0] out_q,
   output logic             strobe_out,
   output logic             busy
);
   localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
   logic wr_i, wr_q, wr_p, imm;
   logic [15:0] period;
   logic [WIDTH-1:0] cur_i, cur_q;
   logic ramp_i, ramp_q;
   logic [WIDTH:0] sum_i, sum_q;
   logic unused_bits;
   assign wr_i = set_stb && set_addr == ADDR + REG_I;
   assign wr_q = set_stb && set_addr == ADDR + REG_Q;
   assign wr_p = set_stb && set_addr == ADDR + REG_PERIOD;
   assign imm = set_data[IMMEDIATE_BIT];
   assign unused_bits = ^set_data[30:WIDTH];
   function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] s);
      return s[WIDTH] != s[WIDTH-1] ? (s[WIDTH] ? MINV : MAXV) : s[WIDTH-1:0];
   endfunction
   // shared ramp period register
   always_ff @(posedge clk) begin
      if (rst) period <= '0;
      else if (wr_p) period <= set_data[PERIOD_MSB:PERIOD_LSB];
   end
   dco_ramp_lane #(.WIDTH(WIDTH), .STEP_SHIFT(STEP_SHIFT)) u_i (
      .clk(clk), .rst(rst), .wr(wr_i), .imm(imm), .wdata(set_data[WIDTH-1:0]),
      .period(period), .cur(cur_i), .ramping(ramp_i)
   );
   dco_ramp_lane #(.WIDTH(WIDTH), .STEP_SHIFT(STEP_SHIFT)) u_q (
      .clk(clk), .rst(rst), .wr(wr_q), .imm(imm), .wdata(set_data[WIDTH-1:0]),
      .period(period), .cur(cur_q), .ramping(ramp_q)
   );
   assign sum_i = {in_i[WIDTH-1], in_i} + {cur_i[WIDTH-1], cur_i};
   assign sum_q = {in_q[WIDTH-1], in_q} + {cur_q[WIDTH-1], cur_q};
   assign busy = ramp_i | ramp_q;
   // saturated sums register on each input strobe and hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         out_i <= '0;
         out_q <= '0;
         strobe_out <= 1'b0;
      end else begin
         strobe_out <= strobe_in;
         if (strobe_in) begin
            out_i <= sat(sum_i);
            out_q <= sat(sum_q);
         end
      end
   end
endmodule

// File: tb/tb_tx_dcoffset.sv
// tb_tx_dcoffset: directed checks of ramping, immediate loads, saturation and reset
module tb_tx_dcoffset;
   logic clk = 0, rst = 1, set_stb = 0, strobe_in = 0;
   logic [7:0] set_addr = 0;
   logic [31:0] set_data = 0;
   logic [15:0] in_i = 0, in_q = 0;
   logic [15:0] out_i, out_q;
   logic strobe_out, busy;
   int errors = 0, checks = 0;

   tx_dcoffset dut (
      .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .in_i(in_i), .in_q(in_q), .strobe_in(strobe_in),
      .out_i(out_i), .out_q(out_q), .strobe_out(strobe_out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      set_stb = 1; set_addr = a; set_data = d;
      tick();
      set_stb = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) tick();
      rst = 0;
      checks++; if (out_i !== 16'd0) begin errors++; $display("FAIL reset_out_i got=%h want=0000", out_i); end
      checks++; if (out_q !== 16'd0) begin errors++; $display("FAIL reset_out_q got=%h want=0000", out_q); end
      checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b want=0", strobe_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (dut.cur_i !== 16'd0) begin errors++; $display("FAIL reset_cur_i got=%h want=0000", dut.cur_i); end
   endtask

   task automatic test_ramp_p0();
      logic [15:0] exp [7] = '{16'd16, 16'd32, 16'd48, 16'd64, 16'd80, 16'd96, 16'd100};
      wr(8'd0, 32'd100);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL p0_busy_rise got=%b want=1", busy); end
      checks++; if (dut.cur_i !== 16'd0) begin errors++; $display("FAIL p0_cur_hold got=%0d want=0", dut.cur_i); end
      for (int k = 0; k < 7; k++) begin
         tick();
         checks++; if (dut.cur_i !== exp[k]) begin errors++; $display("FAIL p0_step%0d got=%0d want=%0d", k, dut.cur_i, exp[k]); end
         checks++; if (busy !== (k < 6)) begin errors++; $display("FAIL p0_busy%0d got=%b want=%b", k, busy, k < 6); end
      end
      checks++; if (dut.cur_q !== 16'd0) begin errors++; $display("FAIL p0_cur_q got=%0d want=0", dut.cur_q); end
   endtask

   task automatic test_ramp_p3();
      logic [15:0] e;
      wr(8'd2, 32'd3);
      wr(8'd1, 32'd40);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL p3_busy_rise got=%b want=1", busy); end
      for (int j = 2; j <= 13; j++) begin
         tick();
         e = j < 5 ? 16'd0 : j < 9 ? 16'd16 : j < 13 ? 16'd32 : 16'd40;
         checks++; if (dut.cur_q !== e) begin errors++; $display("FAIL p3_edge%0d got=%0d want=%0d", j, dut.cur_q, e); end
         checks++; if (busy !== (j < 13)) begin errors++; $display("FAIL p3_busy%0d got=%b want=%b", j, busy, j < 13); end
      end
      wr(8'd2, 32'd0);
   endtask

   task automatic test_immediate();
      wr(8'd1, 32'h8000_FE0C);
      checks++; if (dut.cur_q !== 16'hFE0C) begin errors++; $display("FAIL imm_cur_q got=%h want=fe0c", dut.cur_q); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL imm_busy got=%b want=0", busy); end
      in_i = 0; in_q = 0; strobe_in = 1;
      tick();
      strobe_in = 0;
      checks++; if (out_q !== 16'hFE0C) begin errors++; $display("FAIL imm_out_q got=%h want=fe0c", out_q); end
      checks++; if (out_i !== 16'd100) begin errors++; $display("FAIL imm_out_i got=%0d want=100", out_i); end
      checks++; if (strobe_out !== 1'b1) begin errors++; $display("FAIL imm_strobe got=%b want=1", strobe_out); end
      tick();
      checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL imm_strobe_fall got=%b want=0", strobe_out); end
      checks++; if (out_q !== 16'hFE0C) begin errors++; $display("FAIL imm_hold got=%h want=fe0c", out_q); end
   endtask

   task automatic test_saturation();
      in_i = 16'd32760; in_q = 16'd600; strobe_in = 1;
      tick();
      strobe_in = 0;
      checks++; if (out_i !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%h want=7fff", out_i); end
      checks++; if (out_q !== 16'd100) begin errors++; $display("FAIL sat_q_sum got=%0d want=100", out_q); end
      checks++; if (strobe_out !== 1'b1) begin errors++; $display("FAIL sat_strobe got=%b want=1", strobe_out); end
      wr(8'd0, 32'h8000_FF9C);
      checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL sat_strobe_lat got=%b want=0", strobe_out); end
      in_i = 16'h8008; strobe_in = 1;
      tick();
      in_i = 16'd50;
      tick();
      strobe_in = 0;
      checks++; if (out_i !== 16'hFFCE) begin errors++; $display("FAIL sat_mid got=%h want=ffce", out_i); end
   endtask

   task automatic test_sat_neg();
      in_i = 16'h8008; strobe_in = 1;
      tick();
      strobe_in = 0;
      checks++; if (out_i !== 16'h8000) begin errors++; $display("FAIL sat_neg got=%h want=8000", out_i); end
   endtask

   task automatic test_retarget();
      logic [15:0] exp [4] = '{16'd48, 16'd32, 16'd16, 16'd0};
      wr(8'd0, 32'h8000_0000);
      wr(8'd0, 32'd1000);
      repeat (4) tick();
      checks++; if (dut.cur_i !== 16'd64) begin errors++; $display("FAIL rt_reach got=%0d want=64", dut.cur_i); end
      wr(8'd0, 32'd0);
      checks++; if (dut.cur_i !== 16'd64) begin errors++; $display("FAIL rt_hold got=%0d want=64", dut.cur_i); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rt_busy got=%b want=1", busy); end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (dut.cur_i !== exp[k]) begin errors++; $display("FAIL rt_step%0d got=%0d want=%0d", k, dut.cur_i, exp[k]); end
         checks++; if (busy !== (k < 3)) begin errors++; $display("FAIL rt_busy%0d got=%b want=%b", k, busy, k < 3); end
      end
   endtask

   task automatic test_reset_midramp();
      wr(8'd2, 32'd2);
      wr(8'd0, 32'd100);
      repeat (9) tick();
      checks++; if (dut.cur_i !== 16'd48) begin errors++; $display("FAIL rr_pre got=%0d want=48", dut.cur_i); end
      rst = 1; in_i = 16'd5; strobe_in = 1;
      tick();
      rst = 0;
      checks++; if (dut.cur_i !== 16'd0) begin errors++; $display("FAIL rr_cur got=%0d want=0", dut.cur_i); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got=%b want=0", busy); end
      checks++; if (out_i !== 16'd0) begin errors++; $display("FAIL rr_out got=%0d want=0", out_i); end
      checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL rr_strobe got=%b want=0", strobe_out); end
      strobe_in = 0;
      wr(8'd0, 32'd20);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy2 got=%b want=1", busy); end
      tick();
      checks++; if (dut.cur_i !== 16'd16) begin errors++; $display("FAIL rr_step1 got=%0d want=16", dut.cur_i); end
      tick();
      checks++; if (dut.cur_i !== 16'd20) begin errors++; $display("FAIL rr_step2 got=%0d want=20", dut.cur_i); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_done got=%b want=0", busy); end
   endtask

   initial begin
      test_reset();
      test_ramp_p0();
      test_ramp_p3();
      test_immediate();
      test_saturation();
      test_sat_neg();
      test_retarget();
      test_reset_midramp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tx_dcoffset.md
# tx_dcoffset

Transmit-path DC offset injector: adds a programmable, independently settable I/Q DC term to the baseband stream ahead of the DAC to cancel LO leakage. New targets reach the applied offset through a rate-limited ramp, so retuning never puts a step onto the RF output. A direct load bypasses the ramp. The block sits in the TX DSP chain after interpolation, is programmed over the standard settings bus, and saturates its output.

## Interface
- WIDTH, 16: sample width per I/Q component, two's complement.
- ADDR, 8'd0: base settings address. Registers are:
  - ADDR+0: I target.
  - ADDR+1: Q target.
  - ADDR+2: ramp period.
- STEP_SHIFT, 4: ramp step size is 2^STEP_SHIFT LSB.
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- set_stb, in, 1: settings write strobe.
- set_addr, in, 8: settings address.
- set_data, in, 32: settings data.
- in_i / in_q, in, WIDTH each: input samples.
- strobe_in, in, 1: input sample valid.
- out_i / out_q, out, WIDTH each: corrected, saturated samples.
- strobe_out, out, 1: output sample valid.
- busy, out, 1: high while either lane is ramping.

## Operation
- Target registers (ADDR+0 for I, ADDR+1 for Q):
  - set_data[WIDTH-1:0] is the signed target.
  - set_data[31] = immediate. When set, the applied offset and the target both load at once, with no ramp.
  - Other bits are ignored.
- Period register (ADDR+2): set_data[15:0] = P, the number of idle cycles between steps. P=0 steps every cycle. P is sampled at each timer reload.
- Each lane has a two-state FSM, IDLE and RAMP:
  - IDLE → RAMP when cur ≠ target after a non-immediate write. The timer loads P on entry.
  - In RAMP, if timer==0: step cur toward target by 2^STEP_SHIFT and reload the timer with P; otherwise decrement the timer.
  - If |target−cur| ≤ 2^STEP_SHIFT, cur becomes target and the lane goes to IDLE. The ramp never overshoots.
- Retarget mid-ramp: the target updates and the ramp continues from the present cur toward the new target. The timer is not reloaded.
- Write cycle: a lane does not step on a cycle whose edge registers a write to that lane. A non-immediate write holds cur; an immediate write loads cur. An immediate write mid-ramp forces IDLE.
- Datapath:
  - sum = sign-extended in + sign-extended cur, at WIDTH+1 bits.
  - Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Register the result on strobe_in; hold the output otherwise.
- busy = I lane in RAMP OR Q lane in RAMP.
- Reset values: target 0, cur 0, P 0, both lanes IDLE, out_i/out_q 0, strobe_out 0, busy 0.

## Timing
- Settings write on cycle n:
  - Target/P are visible after edge n+1.
  - busy rises at edge n+1.
  - First ramp step at edge n+2 when P=0, or at edge n+2+P in general. Subsequent steps follow every P+1 cycles.
- Immediate write on cycle n: cur is valid after edge n+1 and busy does not rise.
- busy falls at the same edge where cur reaches target.
- Datapath latency is 1 cycle: strobe_out(n+1) = strobe_in(n), and the output uses the cur value registered at edge n.
- Datapath throughput: 1 sample/cycle. There is no backpressure.
- rst mid-ramp: all state returns to reset values at the next edge, and output is 0 on the following cycle.

## Structure
- Package tx_dcoffset_pkg holds:
  - Register offsets: REG_I=0, REG_Q=1, REG_PERIOD=2.
  - Field positions: IMMEDIATE_BIT=31, PERIOD_LSB/MSB.
  - Lane state enum {IDLE, RAMP}.
- Sub-module dco_ramp_lane: target register, cur, timer and FSM. It is instantiated twice (I, Q), shares P, and outputs cur and ramping.
- The top level contains address decode, the two saturating adders, output registers and the busy OR.

## Test plan
- WIDTH=16, STEP_SHIFT=4, P=0, write I=100, non-immediate:
  - cur_i steps 16, 32, 48, 64, 80, 96, 100 on edges n+2 … n+8.
  - busy is high from edge n+1 until edge n+8.
  - cur_q stays 0.
- P=3, write Q=40:
  - Steps to 16, 32, 40 at edges n+5, n+9, n+13.
  - busy falls at n+13.
- Immediate write: Q = −500 with bit31 set:
  - cur_q = −500 after edge n+1.
  - busy stays 0.
  - in_q=0 with a strobe gives out_q = −500 one cycle later.
- Saturation:
  - cur_i=100, in_i=32760 → out_i=32767.
  - cur_i=−100, in_i=−32760 → out_i=−32768.
  - strobe_out follows strobe_in by exactly 1 cycle.
- Retarget mid-ramp: ramp I toward 1000, then when cur_i=64 write I=0:
  - cur_i holds 64 on the write edge.
  - It then steps 48, 32, 16, 0, and busy falls.
- Reset mid-ramp with cur_i=48:
  - Assert rst for one cycle.
  - cur_i=0, busy=0, out_i=0, strobe_out=0.
  - Following writes behave as from power-up.
